// File: rtl/copiador_memoria.sv
// Block-copy initiator for BancoMemoria: reads a byte, writes it, and moves on, strictly forward.
// Optional read-back check after every write is enabled with the COPIADOR_VERIFICA_EN macro.
module copiador_memoria #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_END  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inicia,
  input  logic [LARGURA_END-1:0]  origem,
  input  logic [LARGURA_END-1:0]  destino,
  input  logic [LARGURA_END-1:0]  quantidade,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro,
  output logic                    EscreveMemoria,
  output logic                    LeMemoria,
  output logic [LARGURA_END-1:0]  Endereco,
  output logic [LARGURA_DADO-1:0] DadoSalvo,
  input  logic [LARGURA_DADO-1:0] DadoCarregado
);

  typedef enum logic [2:0] {
    OCIOSO,
    LE,
    ESCREVE,
`ifdef COPIADOR_VERIFICA_EN
    VERIFICA,
`endif
    FIM
  } estado_t;

  localparam logic [LARGURA_END-1:0] UM   = 1;
  localparam logic [LARGURA_END-1:0] ZERO = '0;

  estado_t                estado;
  logic [LARGURA_END-1:0] ptrO;
  logic [LARGURA_END-1:0] ptrD;
  logic [LARGURA_END-1:0] restante;

  // DadoSalvo doubles as the byte buffer: it is loaded in LE and held until the next LE.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      ocupado        <= 1'b0;
      concluido      <= 1'b0;
      EscreveMemoria <= 1'b0;
      LeMemoria      <= 1'b0;
      Endereco       <= '0;
      DadoSalvo      <= '0;
    end else begin
      concluido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicia) begin
            if (quantidade != ZERO) begin
              ptrO      <= origem;
              ptrD      <= destino;
              restante  <= quantidade;
              estado    <= LE;
              ocupado   <= 1'b1;
              LeMemoria <= 1'b1;
              Endereco  <= origem;
            end else begin
              estado    <= FIM;
              concluido <= 1'b1;
            end
          end
        end
        LE: begin
          DadoSalvo      <= DadoCarregado;
          ptrO           <= ptrO + UM;
          estado         <= ESCREVE;
          LeMemoria      <= 1'b0;
          EscreveMemoria <= 1'b1;
          Endereco       <= ptrD;
        end
        ESCREVE: begin
          restante       <= restante - UM;
          EscreveMemoria <= 1'b0;
`ifdef COPIADOR_VERIFICA_EN
          estado    <= VERIFICA;
          LeMemoria <= 1'b1;
`else
          ptrD <= ptrD + UM;
          // Decision uses the count before this byte's decrement.
          if (restante > UM) begin
            estado    <= LE;
            LeMemoria <= 1'b1;
            Endereco  <= ptrO;
          end else begin
            estado    <= FIM;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
          end
`endif
        end
`ifdef COPIADOR_VERIFICA_EN
        VERIFICA: begin
          ptrD      <= ptrD + UM;
          LeMemoria <= 1'b0;
          if (restante != ZERO) begin
            estado    <= LE;
            LeMemoria <= 1'b1;
            Endereco  <= ptrO;
          end else begin
            estado    <= FIM;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
          end
        end
`endif
        FIM: estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

`ifdef COPIADOR_VERIFICA_EN
  // Sticky mismatch flag; cleared by reset or by any accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      erro <= 1'b0;
    end else if (estado == OCIOSO && inicia) begin
      erro <= 1'b0;
    end else if (estado == VERIFICA && DadoCarregado != DadoSalvo) begin
      erro <= 1'b1;
    end
  end
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_copiador_memoria.sv
// Directed bench for copiador_memoria with a behavioural BancoMemoria model.
module tb_copiador_memoria;

`ifdef COPIADOR_VERIFICA_EN
  localparam int CPB = 3;
`else
  localparam int CPB = 2;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       inicia;
  logic [7:0] origem, destino, quantidade;
  logic       ocupado, concluido, erro, EscreveMemoria, LeMemoria;
  logic [7:0] Endereco, DadoSalvo, DadoCarregado;

  logic [7:0] mem [256];
  logic       corrupt = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         ambos = 0;
  int         cyc;
  bit         acesso;

  always #5 clock = ~clock;

  copiador_memoria #(.LARGURA_DADO(8), .LARGURA_END(8)) dut (
    .clock(clock), .reset(reset), .inicia(inicia),
    .origem(origem), .destino(destino), .quantidade(quantidade),
    .ocupado(ocupado), .concluido(concluido), .erro(erro),
    .EscreveMemoria(EscreveMemoria), .LeMemoria(LeMemoria),
    .Endereco(Endereco), .DadoSalvo(DadoSalvo), .DadoCarregado(DadoCarregado)
  );

  assign DadoCarregado = mem[Endereco];

  always @(posedge clock)
    if (EscreveMemoria)
      mem[Endereco] <= (corrupt && Endereco == 8'd40) ? 8'hFF : DadoSalvo;

  always @(negedge clock)
    if (LeMemoria && EscreveMemoria) ambos++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ends in the middle of the first cycle after the accepting edge (cycle k+1).
  task automatic iniciar(input logic [7:0] o, input logic [7:0] d, input logic [7:0] q);
    @(negedge clock);
    origem = o; destino = d; quantidade = q; inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
  endtask

  // Counts cycles (relative to the accepting edge) until concluido, bounded.
  task automatic waitDone(input int start, output int c, output bit acc);
    c = start;
    acc = LeMemoria | EscreveMemoria;
    while (!concluido && c < 80) begin
      @(negedge clock);
      c++;
      acc = acc | LeMemoria | EscreveMemoria;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; inicia = 1'b0; origem = '0; destino = '0; quantidade = '0;
    repeat (3) @(negedge clock);
    check("rst_ocupado", ocupado, 0);
    check("rst_concluido", concluido, 0);
    check("rst_erro", erro, 0);
    check("rst_strobes", {EscreveMemoria, LeMemoria}, 0);
    check("rst_endereco", Endereco, 0);
    check("rst_dadosalvo", DadoSalvo, 0);
    reset = 1'b0;

    // Basic 4-byte copy
    mem[10] = 8'd1; mem[11] = 8'd2; mem[12] = 8'd3; mem[13] = 8'd4;
    iniciar(8'd10, 8'd40, 8'd4);
    check("t1_le_first", {ocupado, LeMemoria, EscreveMemoria}, 3'b110);
    check("t1_le_addr", Endereco, 10);
    @(negedge clock);
    check("t1_wr_strobe", {LeMemoria, EscreveMemoria}, 2'b01);
    check("t1_wr_addr", Endereco, 40);
    check("t1_wr_data", DadoSalvo, 1);
    waitDone(2, cyc, acesso);
    check("t1_latency", cyc, 1 + CPB * 4);
    check("t1_done_ocupado", ocupado, 0);
    check("t1_erro", erro, 0);
    check("t1_hold_addr", Endereco, 43);
    check("t1_hold_data", DadoSalvo, 4);
    @(negedge clock);
    check("t1_pulse_len", concluido, 0);
    check("t1_mem", {mem[40], mem[41], mem[42], mem[43]}, 32'h01020304);

    // Source pointer wraps 255 -> 0
    mem[254] = 8'd7; mem[255] = 8'd8; mem[0] = 8'd9;
    iniciar(8'd254, 8'd0, 8'd3);
    waitDone(1, cyc, acesso);
    check("t2_latency", cyc, 1 + CPB * 3);
    check("t2_mem", {mem[0], mem[1], mem[2]}, 24'h070807);

    // Zero-length request
    iniciar(8'd20, 8'd30, 8'd0);
    waitDone(1, cyc, acesso);
    check("t3_latency", cyc, 1);
    check("t3_no_access", acesso, 0);
    check("t3_ocupado", ocupado, 0);

    // Overlapping forward copy with a stray start mid-copy
    mem[5] = 8'hAA; mem[6] = 8'd1; mem[7] = 8'd2; mem[8] = 8'd3; mem[200] = 8'h55;
    iniciar(8'd5, 8'd6, 8'd3);
    @(negedge clock);
    origem = 8'd100; destino = 8'd200; quantidade = 8'd5; inicia = 1'b1;
    @(negedge clock);
    inicia = 1'b0;
    waitDone(3, cyc, acesso);
    check("t4_latency", cyc, 1 + CPB * 3);
    check("t4_mem", {mem[6], mem[7], mem[8]}, 24'hAAAAAA);
    check("t4_stray_ignored", mem[200], 8'h55);
    @(negedge clock);
    check("t4_idle_after", {ocupado, concluido}, 2'b00);

    // Reset in the third cycle of a 4-byte copy
    for (int i = 60; i < 64; i++) mem[i] = 8'h00;
    iniciar(8'd10, 8'd60, 8'd4);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_rst_flags", {ocupado, concluido, erro, EscreveMemoria, LeMemoria}, 0);
    check("t5_rst_bus", {Endereco, DadoSalvo}, 0);
    check("t5_mem", {mem[60], mem[61], mem[62], mem[63]}, 32'h01000000);
    iniciar(8'd12, 8'd61, 8'd2);
    check("t5_restart", ocupado, 1);
    waitDone(1, cyc, acesso);
    check("t5_latency", cyc, 1 + CPB * 2);
    check("t5_mem_after", {mem[61], mem[62]}, 16'h0304);

`ifdef COPIADOR_VERIFICA_EN
    // Forced bad write at address 40 must raise a sticky erro
    corrupt = 1'b1;
    iniciar(8'd10, 8'd40, 8'd4);
    waitDone(1, cyc, acesso);
    check("t6_latency", cyc, 13);
    check("t6_erro_done", erro, 1);
    check("t6_mem", mem[40], 8'hFF);
    corrupt = 1'b0;
    @(negedge clock);
    check("t6_erro_sticky", erro, 1);
    iniciar(8'd0, 8'd0, 8'd0);
    check("t6_erro_clear", erro, 0);
`endif

    check("never_both_strobes", ambos, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/copiador_memoria.md
# copiador_memoria

- Memory-side initiator for the `BancoMemoria` write/read interface (`EscreveMemoria`, `LeMemoria`, `Endereco`, `DadoSalvo`, `DadoCarregado`).
- On a single `inicia` pulse it copies a block of `quantidade` bytes from `origem` to `destino` by sequencing read and write strobes into the memory bank.
- Raises `concluido` when the copy is done.
- Sits between the control unit and `BancoMemoria`, and is used for block moves without processor involvement.

## Interface
- `LARGURA_DADO`, 8, data width of memory words
- `LARGURA_END`, 8, address width; addresses wrap modulo 2^LARGURA_END

- `clock`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `inicia`  in  1  start request, sampled only in OCIOSO
- `origem`  in  LARGURA_END  source start address, captured with `inicia`
- `destino`  in  LARGURA_END  destination start address, captured with `inicia`
- `quantidade`  in  LARGURA_END  byte count, 0..255, captured with `inicia`
- `ocupado`  out  1  high while a copy is in progress
- `concluido`  out  1  one-cycle completion pulse
- `erro`  out  1  sticky verify-mismatch flag; constant 0 without VERIFICA_EN
- `EscreveMemoria`  out  1  memory write strobe; memory writes on the rising edge while high
- `LeMemoria`  out  1  memory read enable; the memory drives `DadoCarregado` combinationally
- `Endereco`  out  LARGURA_END  memory address
- `DadoSalvo`  out  LARGURA_DADO  write data to memory
- `DadoCarregado`  in  LARGURA_DADO  read data from memory

## Operation
- States: OCIOSO, LE, ESCREVE, VERIFICA (only with VERIFICA_EN), FIM.
- Internal registers: `ptr_o`, `ptr_d`, `restante`, `buffer`.
- OCIOSO:
  - `inicia`=1 with `quantidade`≠0 → capture the three inputs, go to LE.
  - `inicia`=1 with `quantidade`=0 → go to FIM, with no memory access.
- LE: `LeMemoria`=1, `Endereco`=`ptr_o`. On the edge, `buffer`←`DadoCarregado`, `ptr_o`←`ptr_o`+1; go to ESCREVE.
- ESCREVE: `EscreveMemoria`=1, `Endereco`=`ptr_d`, `DadoSalvo`=`buffer`. On the edge, `restante`←`restante`−1.
  - With VERIFICA_EN: go to VERIFICA.
  - Without VERIFICA_EN: `ptr_d`←`ptr_d`+1, then go to LE if `restante`>1, else FIM.
- FIM: `concluido`=1 for exactly one cycle, then OCIOSO.
- `ocupado`=1 in LE, ESCREVE and VERIFICA only.
- `inicia` outside OCIOSO is ignored.
- `LeMemoria` and `EscreveMemoria` are never high in the same cycle.
- In inactive cycles, `Endereco` and `DadoSalvo` hold their last values.
- Address wrap-around: 255+1 → 0 on both pointers; no error.
- Overlapping regions: strictly forward, byte by byte. Byte i is read before byte i is written. Example: `destino`=`origem`+1 replicates the first byte across the block. This is the required behaviour.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Reset (any state, including mid-copy): next cycle OCIOSO with all outputs 0 and `erro` cleared. Bytes already written stay written.

## Timing
- `inicia` is accepted at edge k. The first LE cycle is k+1.
- Each byte takes 2 cycles (LE, ESCREVE), or 3 with VERIFICA_EN.
- `concluido` is high in cycle k+1+2N (k+1+3N with VERIFICA_EN).
- `quantidade`=0: `concluido` in cycle k+1.
- A new `inicia` is accepted the cycle after FIM, at the earliest.
- Reset values: `ocupado`=0, `concluido`=0, `erro`=0, `EscreveMemoria`=0, `LeMemoria`=0, `Endereco`=0, `DadoSalvo`=0.

## Configuration
- Macro: `COPIADOR_VERIFICA_EN`.
- Defined: after each ESCREVE, the block enters VERIFICA.
  - VERIFICA drives `LeMemoria`=1 and `Endereco`=`ptr_d`.
  - On the edge, if `DadoCarregado`≠`buffer`, `erro`←1.
  - Then `ptr_d`←`ptr_d`+1, and go to LE or FIM by `restante`.
  - `erro` is sticky until reset or the next accepted `inicia`. The copy continues after a mismatch.
- Undefined: VERIFICA state and compare logic are absent; `erro` is tied 0; 2 cycles per byte.

## Test plan
- Preload mem[10..13]=1,2,3,4; `origem`=10, `destino`=40, `quantidade`=4 → mem[40..43]=1,2,3,4; `concluido` pulses once in cycle k+9 (k+13 verify build); `erro`=0.
- `origem`=254, `destino`=0, `quantidade`=3 with mem[254]=7, mem[255]=8, mem[0]=9 → source pointer wraps to 0 for the third byte; result mem[0]=7, mem[1]=8, mem[2]=7.
- `quantidade`=0 → `concluido` in cycle k+1; `EscreveMemoria` and `LeMemoria` never assert.
- Overlap: mem[5]=0xAA, `origem`=5, `destino`=6, `quantidade`=3 → mem[6..8]=0xAA; second `inicia` pulsed mid-copy is ignored.
- Reset asserted in the 3rd cycle of a 4-byte copy → next cycle all outputs 0 and state OCIOSO; only mem[dst] holds the first byte; a new `inicia` is then accepted normally.
- Verify build: memory model forces a write to addr 40 to store 0xFF → `erro`=1 after that VERIFICA cycle; it stays 1 through `concluido` and clears on the next accepted `inicia`.
